// File: rtl/jtag_host_if.sv
// jtag_host_if: command/response and JTAG pin bundle for jtag_host
// Signals: cmdValid/cmdReady/cmdIsIr/cmdData command handshake, rspValid/rspData scan result,
// tck/tms/tdi driven toward the target, tdo returned from the target.
// Modports: slave = jtag_host, master = command source plus target pins.
interface jtag_host_if;
    logic        cmdValid;
    logic        cmdReady;
    logic        cmdIsIr;
    logic [15:0] cmdData;
    logic        rspValid;
    logic [15:0] rspData;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;
    modport master (
        output cmdValid, cmdIsIr, cmdData, tdo,
        input  cmdReady, rspValid, rspData, tck, tms, tdi
    );
    modport slave (
        input  cmdValid, cmdIsIr, cmdData, tdo,
        output cmdReady, rspValid, rspData, tck, tms, tdi
    );
endinterface

// File: rtl/jtag_host.sv
// jtag_host: JTAG initiator running one full IR or DR scan per command and returning captured TDO
// Ports: clk system clock; rstn asynchronous active-low reset;
// bus (jtag_host_if.slave): cmdValid/cmdReady/cmdIsIr/cmdData in, rspValid/rspData out,
// tck/tms/tdi out, tdo in (asynchronous, synchronized internally).
// Macro JTAG_HOST_INIT_RESET_EN: after reset, drive 5 TCKs of TMS=1 then one of TMS=0 to park
// the target in Run-Test/Idle before accepting commands.
module jtag_host #(
    parameter int TCK_DIV = 4,
    parameter int IR_LEN  = 8,
    parameter int DR_LEN  = 16
) (
    input logic        clk,
    input logic        rstn,
    jtag_host_if.slave bus
);
    localparam int P  = 2 * TCK_DIV;
    localparam int CW = $clog2(P);
    typedef enum logic [1:0] {IDLE, SCAN, INIT} state_t;
`ifdef JTAG_HOST_INIT_RESET_EN
    localparam state_t RST_STATE = INIT;
`else
    localparam state_t RST_STATE = IDLE;
`endif
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    idx, idx_n;
    logic          is_ir, is_ir_n;
    logic [15:0]   data, data_n, cap, cap_n, rsp_data_n;
    logic          tck_n, tms_n, tdi_n, ready_n, rsp_valid_n;
    logic [1:0]    sync;
    logic [4:0]    pre, len, total;
    logic [3:0]    off;
    logic          shifting, tms_seq;

    // Scan layout: pre header TCKs, len shift TCKs, then Exit1->Update->Idle (two TCKs).
    always_comb begin
        pre      = is_ir ? 5'd4 : 5'd3;
        len      = is_ir ? 5'(IR_LEN) : 5'(DR_LEN);
        total    = state == INIT ? 5'd6 : pre + len + 5'd2;
        off      = 4'(idx - pre);
        shifting = state == SCAN && idx >= pre && idx < pre + len;
        tms_seq  = state == INIT ? idx != 5'd5 :
                   idx < pre ? (is_ir ? idx < 5'd2 : idx == 5'd0) :
                   idx >= pre + len - 5'd1 && idx <= pre + len;
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        is_ir_n     = is_ir;
        data_n      = data;
        cap_n       = cap;
        tck_n       = bus.tck;
        tms_n       = bus.tms;
        tdi_n       = bus.tdi;
        ready_n     = bus.cmdReady;
        rsp_valid_n = 1'b0;
        rsp_data_n  = bus.rspData;
        if (state == IDLE) begin
            ready_n = 1'b1;
            if (bus.cmdValid && bus.cmdReady) begin
                state_n = SCAN;
                ready_n = 1'b0;
                cnt_n   = '0;
                idx_n   = '0;
                is_ir_n = bus.cmdIsIr;
                data_n  = bus.cmdData;
                cap_n   = '0;
            end
        end else if (idx == total) begin
            state_n     = IDLE;
            ready_n     = 1'b1;
            tck_n       = 1'b0;
            tdi_n       = 1'b0;
            rsp_valid_n = state == SCAN;
            rsp_data_n  = state == SCAN ? cap : bus.rspData;
        end else begin
            cnt_n = cnt == CW'(P - 1) ? '0 : cnt + CW'(1);
            idx_n = cnt == CW'(P - 1) ? idx + 5'd1 : idx;
            if (cnt == '0) begin
                tck_n = 1'b0;
                tms_n = tms_seq;
                tdi_n = shifting && data[off];
            end
            if (cnt == CW'(TCK_DIV))
                tck_n = 1'b1;
            // Last clk of the high phase: the target changed TDO on the previous falling edge.
            if (cnt == CW'(P - 1) && shifting)
                cap_n[off] = sync[1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= RST_STATE;
            cnt          <= '0;
            idx          <= '0;
            is_ir        <= 1'b0;
            data         <= '0;
            cap          <= '0;
            sync         <= '0;
            bus.tck      <= 1'b0;
            bus.tms      <= 1'b1;
            bus.tdi      <= 1'b0;
            bus.cmdReady <= 1'b0;
            bus.rspValid <= 1'b0;
            bus.rspData  <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            idx          <= idx_n;
            is_ir        <= is_ir_n;
            data         <= data_n;
            cap          <= cap_n;
            sync         <= {sync[0], bus.tdo};
            bus.tck      <= tck_n;
            bus.tms      <= tms_n;
            bus.tdi      <= tdi_n;
            bus.cmdReady <= ready_n;
            bus.rspValid <= rsp_valid_n;
            bus.rspData  <= rsp_data_n;
        end
    end
endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host: self-checking bench for jtag_host against a behavioural IEEE 1149.1 TAP target
module tb_jtag_host;
    localparam int D   = 3;
    localparam int IRL = 8;
    localparam int DRL = 16;

    typedef enum {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                  SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic trst = 1'b1;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jtag_host_if jif();
    jtag_host #(.TCK_DIV(D), .IR_LEN(IRL), .DR_LEN(DRL)) dut (.clk(clk), .rstn(rstn), .bus(jif));

    // Target TAP model: state walk on rising TCK, TDO launched on falling TCK.
    tap_t        tap = RTI;
    logic [15:0] ir_sh = '0, dr_sh = '0, ir_upd = '0, dr_upd = '0;
    logic [15:0] dr_cap = '0;
    logic [31:0] tms_hist = '0;
    int          tck_rises = 0;
    int          bad_tdi = 0;
    logic        tdo_m = 1'b0;
    assign jif.tdo = tdo_m;

    function automatic tap_t tap_next(tap_t s, logic m);
        case (s)
            TLR:     return m ? TLR  : RTI;
            RTI:     return m ? SDR  : RTI;
            SDR:     return m ? SIR  : CDR;
            CDR:     return m ? E1DR : SHDR;
            SHDR:    return m ? E1DR : SHDR;
            E1DR:    return m ? UDR  : PDR;
            PDR:     return m ? E2DR : PDR;
            E2DR:    return m ? UDR  : SHDR;
            UDR:     return m ? SDR  : RTI;
            SIR:     return m ? TLR  : CIR;
            CIR:     return m ? E1IR : SHIR;
            SHIR:    return m ? E1IR : SHIR;
            E1IR:    return m ? UIR  : PIR;
            PIR:     return m ? E2IR : PIR;
            E2IR:    return m ? UIR  : SHIR;
            default: return m ? SDR  : RTI;
        endcase
    endfunction

    always @(posedge jif.tck or posedge trst) begin
        if (trst) begin
            tap <= RTI;
        end else begin
            tck_rises <= tck_rises + 1;
            tms_hist  <= {tms_hist[30:0], jif.tms};
            if (tap != SHDR && tap != SHIR && jif.tdi !== 1'b0)
                bad_tdi <= bad_tdi + 1;
            case (tap)
                CDR:  dr_sh  <= dr_cap;
                SHDR: dr_sh  <= (dr_sh >> 1) | (16'(jif.tdi) << (DRL - 1));
                UDR:  dr_upd <= dr_sh;
                CIR:  ir_sh  <= 16'h0001;
                SHIR: ir_sh  <= (ir_sh >> 1) | (16'(jif.tdi) << (IRL - 1));
                UIR:  ir_upd <= ir_sh;
                default: ;
            endcase
            tap <= tap_next(tap, jif.tms);
        end
    end

    always @(negedge jif.tck)
        tdo_m <= tap == SHDR ? dr_sh[0] : tap == SHIR ? ir_sh[0] : 1'b0;

    function automatic int n_tcks(logic ir);
        return ir ? IRL + 6 : DRL + 5;
    endfunction

    function automatic int exp_lat(logic ir);
        return 2 * D * n_tcks(ir) + 1;
    endfunction

    function automatic logic [15:0] len_mask(logic ir);
        return ir ? 16'((32'd1 << IRL) - 1) : 16'((32'd1 << DRL) - 1);
    endfunction

    // Oldest TMS in the MSB: header, shift zeros with a final 1, then Update (1) and Idle (0).
    function automatic logic [31:0] exp_tms(logic ir);
        logic [31:0] t;
        t = ir ? 32'b1100 : 32'b100;
        for (int i = 0; i < (ir ? IRL : DRL) - 1; i++)
            t = t << 1;
        return (t << 3) | 32'b110;
    endfunction

    function automatic logic [31:0] hist_mask(int n);
        return (32'd1 << n) - 1;
    endfunction

    task automatic wait_ready(output int k);
        k = 0;
        while (jif.cmdReady !== 1'b1 && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic do_cmd(input logic ir, input logic [15:0] d, output int lat,
                          output logic [15:0] rsp, output int rises);
        int k, r0;
        wait_ready(k);
        jif.cmdValid = 1'b1;
        jif.cmdIsIr  = ir;
        jif.cmdData  = d;
        @(posedge clk);
        #1;
        jif.cmdValid = 1'b0;
        r0  = tck_rises;
        lat = 0;
        while (jif.rspValid !== 1'b1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rsp   = jif.rspData;
        rises = tck_rises - r0;
    endtask

    task automatic test_reset;
        int k, r0, exp_k, exp_r;
        jif.cmdValid = 1'b0;
        jif.cmdIsIr  = 1'b0;
        jif.cmdData  = '0;
        repeat (2) @(posedge clk);
        #1;
        trst = 1'b0;
        tests++;
        if ({jif.tck, jif.tms, jif.tdi} !== 3'b010) begin
            fails++;
            $display("FAIL reset_pins: got tck/tms/tdi=%b expected 010", {jif.tck, jif.tms, jif.tdi});
        end
        tests++;
        if ({jif.cmdReady, jif.rspValid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_hs: got ready/valid=%b expected 00", {jif.cmdReady, jif.rspValid});
        end
        tests++;
        if (jif.rspData !== 16'h0) begin
            fails++;
            $display("FAIL reset_rsp: got %h expected 0000", jif.rspData);
        end
        r0   = tck_rises;
        rstn = 1'b1;
        wait_ready(k);
`ifdef JTAG_HOST_INIT_RESET_EN
        exp_k = 12 * D + 1;
        exp_r = 6;
        tests++;
        if ((tms_hist & 32'h3f) !== 32'b111110) begin
            fails++;
            $display("FAIL init_tms: got %b expected 111110", tms_hist[5:0]);
        end
`else
        exp_k = 1;
        exp_r = 0;
`endif
        tests++;
        if (k !== exp_k) begin
            fails++;
            $display("FAIL reset_ready_cycle: got %0d expected %0d", k, exp_k);
        end
        tests++;
        if (tck_rises - r0 !== exp_r) begin
            fails++;
            $display("FAIL reset_tcks: got %0d expected %0d", tck_rises - r0, exp_r);
        end
        tests++;
        if (tap !== RTI) begin
            fails++;
            $display("FAIL reset_tap: got %s expected RTI", tap.name());
        end
    endtask

    task automatic test_ir_scan;
        int lat, rises;
        logic [15:0] rsp;
        do_cmd(1'b1, 16'h00A5, lat, rsp, rises);
        tests++;
        if (lat !== exp_lat(1'b1)) begin
            fails++;
            $display("FAIL ir_latency: got %0d expected %0d", lat, exp_lat(1'b1));
        end
        tests++;
        if (rsp !== 16'h0001) begin
            fails++;
            $display("FAIL ir_rsp: got %h expected 0001", rsp);
        end
        tests++;
        if ((tms_hist & hist_mask(14)) !== exp_tms(1'b1)) begin
            fails++;
            $display("FAIL ir_tms: got %b expected %b", tms_hist[13:0], exp_tms(1'b1));
        end
        tests++;
        if (ir_upd !== 16'h00A5 || tap !== RTI || rises !== 14) begin
            fails++;
            $display("FAIL ir_target: got upd=%h tap=%s tcks=%0d expected 00a5 RTI 14", ir_upd, tap.name(), rises);
        end
    endtask

    task automatic test_dr_scan;
        int lat, rises;
        logic [15:0] rsp;
        dr_cap = 16'h1234;
        do_cmd(1'b0, 16'hBEEF, lat, rsp, rises);
        tests++;
        if (lat !== exp_lat(1'b0) || rises !== 21) begin
            fails++;
            $display("FAIL dr_timing: got lat=%0d tcks=%0d expected %0d 21", lat, rises, exp_lat(1'b0));
        end
        tests++;
        if (rsp !== 16'h1234 || dr_upd !== 16'hBEEF) begin
            fails++;
            $display("FAIL dr_data: got rsp=%h upd=%h expected 1234 beef", rsp, dr_upd);
        end
        @(posedge clk);
        #1;
        tests++;
        if (jif.rspValid !== 1'b0 || jif.rspData !== 16'h1234 || jif.tms !== 1'b0) begin
            fails++;
            $display("FAIL dr_after: got valid=%b rsp=%h tms=%b expected 0 1234 0", jif.rspValid, jif.rspData, jif.tms);
        end
    endtask

    task automatic test_random;
        int lat, rises, b0;
        logic ir;
        logic [15:0] d, rsp, exp_rsp, upd;
        for (int i = 0; i < 12; i++) begin
            ir     = 1'($urandom_range(0, 1));
            d      = 16'($urandom);
            dr_cap = 16'($urandom);
            exp_rsp = ir ? 16'h0001 : dr_cap & len_mask(1'b0);
            b0 = bad_tdi;
            do_cmd(ir, d, lat, rsp, rises);
            upd = ir ? ir_upd : dr_upd;
            tests++;
            if (lat !== exp_lat(ir) || rises !== n_tcks(ir)) begin
                fails++;
                $display("FAIL rnd_timing[%0d]: got lat=%0d tcks=%0d expected %0d %0d", i, lat, rises, exp_lat(ir), n_tcks(ir));
            end
            tests++;
            if (rsp !== exp_rsp) begin
                fails++;
                $display("FAIL rnd_rsp[%0d]: got %h expected %h", i, rsp, exp_rsp);
            end
            tests++;
            if (upd !== (d & len_mask(ir)) || tap !== RTI) begin
                fails++;
                $display("FAIL rnd_target[%0d]: got upd=%h tap=%s expected %h RTI", i, upd, tap.name(), d & len_mask(ir));
            end
            tests++;
            if ((tms_hist & hist_mask(n_tcks(ir))) !== exp_tms(ir) || bad_tdi !== b0) begin
                fails++;
                $display("FAIL rnd_pins[%0d]: got tms=%h stray_tdi=%0d expected %h 0", i, tms_hist, bad_tdi - b0, exp_tms(ir));
            end
        end
    endtask

    task automatic test_back_to_back;
        int k, early, lat;
        logic [15:0] d1, d2, rsp1;
        d1 = 16'($urandom);
        d2 = 16'($urandom);
        dr_cap = 16'($urandom);
        early = 0;
        wait_ready(k);
        jif.cmdValid = 1'b1;
        jif.cmdIsIr  = 1'b0;
        jif.cmdData  = d1;
        @(posedge clk);
        #1;
        jif.cmdIsIr = 1'b1;
        jif.cmdData = d2;
        k = 0;
        while (jif.rspValid !== 1'b1 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
            if (jif.rspValid !== 1'b1 && jif.cmdReady !== 1'b0)
                early++;
        end
        rsp1 = jif.rspData;
        tests++;
        if (k !== exp_lat(1'b0) || early !== 0 || jif.cmdReady !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first: got lat=%0d early_ready=%0d ready=%b expected %0d 0 1", k, early, jif.cmdReady, exp_lat(1'b0));
        end
        tests++;
        if (rsp1 !== dr_cap || dr_upd !== d1) begin
            fails++;
            $display("FAIL b2b_first_data: got rsp=%h upd=%h expected %h %h", rsp1, dr_upd, dr_cap, d1);
        end
        @(posedge clk);
        #1;
        jif.cmdValid = 1'b0;
        tests++;
        if (jif.cmdReady !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept: got ready=%b expected 0", jif.cmdReady);
        end
        lat = 0;
        while (jif.rspValid !== 1'b1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tests++;
        if (lat !== exp_lat(1'b1) || jif.rspData !== 16'h0001 || ir_upd !== (d2 & len_mask(1'b1))) begin
            fails++;
            $display("FAIL b2b_second: got lat=%0d rsp=%h upd=%h expected %0d 0001 %h", lat, jif.rspData, ir_upd, exp_lat(1'b1), d2 & len_mask(1'b1));
        end
    endtask

    task automatic test_reset_mid_scan;
        int k, r0, lat, rises, pulses;
        logic [15:0] d, rsp;
        dr_cap = 16'($urandom);
        wait_ready(k);
        jif.cmdValid = 1'b1;
        jif.cmdIsIr  = 1'b0;
        jif.cmdData  = 16'($urandom);
        @(posedge clk);
        #1;
        jif.cmdValid = 1'b0;
        r0 = tck_rises;
        k  = 0;
        while (tck_rises - r0 < 7 && k < 400) begin
            @(posedge clk);
            k++;
        end
        #2;
        rstn = 1'b0;
        #1;
        tests++;
        if ({jif.tck, jif.tms, jif.cmdReady, jif.rspValid} !== 4'b0100 || jif.rspData !== 16'h0) begin
            fails++;
            $display("FAIL midrst_pins: got tck/tms/ready/valid=%b rsp=%h expected 0100 0000",
                     {jif.tck, jif.tms, jif.cmdReady, jif.rspValid}, jif.rspData);
        end
        pulses = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (jif.rspValid !== 1'b0)
                pulses++;
        end
`ifndef JTAG_HOST_INIT_RESET_EN
        trst = 1'b1;
        #1;
        trst = 1'b0;
`endif
        rstn = 1'b1;
        k = 0;
        while (jif.cmdReady !== 1'b1 && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
            if (jif.rspValid !== 1'b0)
                pulses++;
        end
        tests++;
        if (pulses !== 0 || tap !== RTI) begin
            fails++;
            $display("FAIL midrst_recover: got rsp_pulses=%0d tap=%s expected 0 RTI", pulses, tap.name());
        end
        d = 16'($urandom);
        do_cmd(1'b0, d, lat, rsp, rises);
        tests++;
        if (lat !== exp_lat(1'b0) || rsp !== dr_cap || dr_upd !== d) begin
            fails++;
            $display("FAIL midrst_next: got lat=%0d rsp=%h upd=%h expected %0d %h %h", lat, rsp, dr_upd, exp_lat(1'b0), dr_cap, d);
        end
    endtask

    initial begin
        test_reset;
        test_ir_scan;
        test_dr_scan;
        test_random;
        test_back_to_back;
        test_reset_mid_scan;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/jtag_host.md
# jtag_host

JTAG initiator that drives TCK/TMS/TDI and samples TDO, so on-chip logic or a test harness can talk to a JTAG target such as the memory controller's TAP port without hand-toggling switches. It accepts one shift command at a time over a valid/ready handshake. It walks the IEEE 1149.1 TAP from Run-Test/Idle through a full IR or DR scan and back, and returns the captured TDO bits. It sits between a command source (sequencer, UART bridge, testbench) and the board JTAG pins.

## Interface
- TCK_DIV, 4: clk cycles per TCK half-period; legal range ≥3.
- IR_LEN, 8: instruction register length; legal range 1..16.
- DR_LEN, 16: data register length; legal range 1..16.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- cmdValid  in  1  command present.
- cmdReady  out  1  host idle and able to accept.
- cmdIsIr  in  1  1 = IR scan, 0 = DR scan.
- cmdData  in  16  bits to shift; LSB first; IR uses [IR_LEN-1:0].
- rspValid  out  1  one-cycle pulse when the scan completes.
- rspData  out  16  captured TDO, LSB = first bit; upper unused bits 0; holds until next rspValid.
- tck, tms, tdi  out  1  JTAG outputs.
- tdo  in  1  JTAG input; asynchronous to clk.

## Operation
- Reset values: tck=0, tms=1, tdi=0, cmdReady=0, rspValid=0, rspData=0.
- Accept: on the clk edge where cmdValid && cmdReady, latch cmdIsIr and cmdData, then drop cmdReady.
- States: INIT → IDLE → SCAN → IDLE. INIT is present only with the macro; otherwise reset goes directly to IDLE.
- SCAN emits a fixed TMS sequence, one value per TCK.
  - IR: 1,1,0,0, then IR_LEN shift TCKs (TMS=0, last =1), then 1,0. Total IR_LEN+6 TCKs.
  - DR: 1,0,0, then DR_LEN shift TCKs (TMS=0, last =1), then 1,0. Total DR_LEN+5 TCKs.
- TDI carries latched bit i on shift TCK i and is 0 on all non-shift TCKs.
- tdo passes through a 2-flop synchronizer.
- rspData bit i = synchronized tdo sampled during shift TCK i.
- The target TAP is left in Run-Test/Idle after every command.
- cmdValid while busy: ignored (cmdReady low). Nothing is queued.
- A command may be accepted in the same cycle rspValid pulses.
- Reset mid-scan: outputs return to reset values immediately and the partial rspData is discarded. Target TAP state is unknown afterward: the INIT sequence recovers it if the macro is compiled in; otherwise recovery is the user's responsibility.

## Timing
- TCK period = 2·TCK_DIV clk cycles, with the low phase first.
- tms/tdi update on the first clk of each low phase and are stable for the full period.
- tck rises after TCK_DIV clks, so the target samples tms/tdi on that rising edge.
- tdo is sampled on the last clk of each high phase, just before tck falls. This respects the target updating TDO on the falling edge.
- The command accepted at cycle 0 starts its first low phase at cycle 1.
- With N TCKs, rspValid=1 and cmdReady=1 at cycle 2·TCK_DIV·N + 1.
- Defaults: IR scan 14 TCKs → 113 clks; DR scan 21 TCKs → 169 clks.
- tck idles low; tms holds its last value (0) while IDLE.

## Configuration
- JTAG_HOST_INIT_RESET_EN defined:
  - After rstn deasserts, INIT drives 5 TCKs with TMS=1 (Test-Logic-Reset), then 1 TCK with TMS=0 (Run-Test/Idle), with TDI=0.
  - cmdReady rises at cycle 12·TCK_DIV+1 after reset release.
  - No rspValid is produced for INIT.
- Undefined: INIT is absent; cmdReady=1 on the first clk after reset release, and the target is assumed to already be in Run-Test/Idle.

## Test plan
- Reset, macro on, TCK_DIV=4: tms=1 for 5 TCKs then 0; tck count = 6; cmdReady rises at cycle 49 → pass.
- IR scan, cmdData=0x00A5, model TAP returning IR capture 0x01: TMS trace 1,1,0,0,0×7,1,1,0; TDI during shift = 1,0,1,0,0,1,0,1; rspData=0x0001 at cycle 113.
- DR scan, cmdData=0xBEEF, model returning 0x1234: 21 TCKs; model DR update = 0xBEEF; rspData=0x1234; rspValid exactly one cycle.
- Back-to-back: second cmdValid held high during scan → not accepted until rspValid cycle; accepted that cycle; second scan starts the next clk.
- rstn pulsed low at TCK 7 of a DR scan: tck=0, tms=1, cmdReady=0 immediately; rspValid never pulses; INIT reruns and the next DR scan completes correctly.
- Macro off: cmdReady=1 one clk after reset; IR scan with TCK_DIV=3 completes at cycle 85 with tdo sampled correctly through the synchronizer.
